// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised 1W/2R register file with a hardware clear sweep
// Optional write-through forwarding to the read ports when REG_FILE_BYPASS_EN is defined.
module reg_file_param #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             WR_EN,
  input  logic [AW-1:0]    WR_ADDR,
  input  logic [WIDTH-1:0] WR_DATA,
  output logic             WR_REJECT,
  input  logic             RD1_EN,
  input  logic [AW-1:0]    RD1_ADDR,
  output logic [WIDTH-1:0] RD1_DATA,
  input  logic             RD2_EN,
  input  logic [AW-1:0]    RD2_ADDR,
  output logic [WIDTH-1:0] RD2_DATA,
  input  logic             CLR_REQ,
  output logic             CLR_BUSY,
  output logic             CLR_DONE
);

  typedef enum logic {IDLE, SWEEP} state_t;

  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             reject_q, reject_d;
  logic [WIDTH-1:0] rd1_q, rd1_d;
  logic [WIDTH-1:0] rd2_q, rd2_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic wr_addr_ok, rd1_addr_ok, rd2_addr_ok, wr_accept;

  assign wr_addr_ok  = ({1'b0, WR_ADDR}  < DEPTH_EXT);
  assign rd1_addr_ok = ({1'b0, RD1_ADDR} < DEPTH_EXT);
  assign rd2_addr_ok = ({1'b0, RD2_ADDR} < DEPTH_EXT);
  // A write arriving alongside CLR_REQ still lands; the sweep clears it afterwards.
  assign wr_accept   = (state_q == IDLE) && WR_EN && wr_addr_ok;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    reject_d = (state_q == SWEEP) && WR_EN && wr_addr_ok;
    case (state_q)
      IDLE: begin
        if (CLR_REQ) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SWEEP);
  end

  always_comb begin
    rd1_d = rd1_q;
    rd2_d = rd2_q;
    if (RD1_EN) begin
      rd1_d = rd1_addr_ok ? mem_q[RD1_ADDR] : '0;
    end
    if (RD2_EN) begin
      rd2_d = rd2_addr_ok ? mem_q[RD2_ADDR] : '0;
    end
`ifdef REG_FILE_BYPASS_EN
    if (RD1_EN && wr_accept && (RD1_ADDR == WR_ADDR)) begin
      rd1_d = WR_DATA;
    end
    if (RD2_EN && wr_accept && (RD2_ADDR == WR_ADDR)) begin
      rd2_d = WR_DATA;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      reject_q <= 1'b0;
      rd1_q    <= '0;
      rd2_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      reject_q <= reject_d;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (state_q == SWEEP) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_accept) begin
      mem_q[WR_ADDR] <= WR_DATA;
    end
  end

  assign WR_REJECT = reject_q;
  assign CLR_BUSY  = busy_q;
  assign CLR_DONE  = done_q;
  assign RD1_DATA  = rd1_q;
  assign RD2_DATA  = rd2_q;

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - scoreboard bench for reg_file_param (default 8x16 build)
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        WR_EN;
  logic [2:0]  WR_ADDR;
  logic [15:0] WR_DATA;
  logic        WR_REJECT;
  logic        RD1_EN;
  logic [2:0]  RD1_ADDR;
  logic [15:0] RD1_DATA;
  logic        RD2_EN;
  logic [2:0]  RD2_ADDR;
  logic [15:0] RD2_DATA;
  logic        CLR_REQ;
  logic        CLR_BUSY;
  logic        CLR_DONE;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] exp1_q[$];
  logic [15:0] exp2_q[$];
  logic        v1_q = 1'b0;
  logic        v2_q = 1'b0;

  reg_file_param #(.WIDTH(16), .DEPTH(8), .AW(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .WR_EN    (WR_EN),
    .WR_ADDR  (WR_ADDR),
    .WR_DATA  (WR_DATA),
    .WR_REJECT(WR_REJECT),
    .RD1_EN   (RD1_EN),
    .RD1_ADDR (RD1_ADDR),
    .RD1_DATA (RD1_DATA),
    .RD2_EN   (RD2_EN),
    .RD2_ADDR (RD2_ADDR),
    .RD2_DATA (RD2_DATA),
    .CLR_REQ  (CLR_REQ),
    .CLR_BUSY (CLR_BUSY),
    .CLR_DONE (CLR_DONE)
  );

  always #5 clk = ~clk;

  // A read issued at an edge produces data visible after that edge.
  always @(posedge clk) begin
    v1_q <= RD1_EN;
    v2_q <= RD2_EN;
  end

  always @(negedge clk) begin
    if (v1_q) begin
      n_cmp++;
      if (exp1_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd1_unexpected: got %h with no expected entry", RD1_DATA);
      end else begin
        automatic logic [15:0] e = exp1_q.pop_front();
        if (RD1_DATA !== e) begin
          n_fail++;
          $display("FAIL rd1_data: got %h expected %h", RD1_DATA, e);
        end
      end
    end
    if (v2_q) begin
      n_cmp++;
      if (exp2_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd2_unexpected: got %h with no expected entry", RD2_DATA);
      end else begin
        automatic logic [15:0] e = exp2_q.pop_front();
        if (RD2_DATA !== e) begin
          n_fail++;
          $display("FAIL rd2_data: got %h expected %h", RD2_DATA, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    WR_EN   = 1'b0;
    RD1_EN  = 1'b0;
    RD2_EN  = 1'b0;
    CLR_REQ = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    WR_EN   = 1'b1;
    WR_ADDR = a;
    WR_DATA = d;
  endtask

  task automatic rd1(input logic [2:0] a, input logic [15:0] e);
    RD1_EN   = 1'b1;
    RD1_ADDR = a;
    exp1_q.push_back(e);
  endtask

  task automatic rd2(input logic [2:0] a, input logic [15:0] e);
    RD2_EN   = 1'b1;
    RD2_ADDR = a;
    exp2_q.push_back(e);
  endtask

  task automatic fill();
    for (int i = 0; i < 8; i++) begin
      wr(3'(i), 16'(16'h0101 * i));
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] coll;
    int busy_cnt;
    logic done_seen;

    rst_n = 1'b0; WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0;
    RD1_EN = 1'b0; RD1_ADDR = '0; RD2_EN = 1'b0; RD2_ADDR = '0; CLR_REQ = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_busy", CLR_BUSY, 0);
    chk("rst_done", CLR_DONE, 0);
    chk("rst_reject", WR_REJECT, 0);
    chk("rst_rd1", RD1_DATA, 0);
    chk("rst_rd2", RD2_DATA, 0);
    for (int i = 0; i < 8; i++) begin
      rd1(3'(i), 16'h0000);
      rd2(3'(7 - i), 16'h0000);
      tick();
    end

    // write then read, then hold with enable low
    wr(3'd3, 16'hBEEF); tick();
    rd1(3'd3, 16'hBEEF); rd2(3'd3, 16'hBEEF); tick();
    wr(3'd3, 16'h1234); tick();
    chk("rd1_hold", RD1_DATA, 16'hBEEF);
    chk("rd2_hold", RD2_DATA, 16'hBEEF);
    rd2(3'd3, 16'h1234); tick();

    // same-cycle read/write collision
`ifdef REG_FILE_BYPASS_EN
    coll = 16'h5555;
`else
    coll = 16'hAAAA;
`endif
    wr(3'd5, 16'hAAAA); tick();
    wr(3'd5, 16'h5555); rd1(3'd5, coll); rd2(3'd5, coll); tick();
    rd1(3'd5, 16'h5555); tick();

    // clear sweep with a rejected write at sweep cycle 4
    fill();
    chk("pre_sweep_busy", CLR_BUSY, 0);
    CLR_REQ = 1'b1; tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("sweep_busy_%0d", i), CLR_BUSY, 1);
      chk($sformatf("sweep_done_%0d", i), CLR_DONE, 0);
      chk($sformatf("sweep_reject_%0d", i), WR_REJECT, (i == 5) ? 1 : 0);
      if (i == 2) begin
        rd1(3'd7, 16'h0707);
        rd2(3'd0, 16'h0000);
      end
      if (i == 3) rd1(3'd2, 16'h0000);
      if (i == 4) wr(3'd1, 16'hFFFF);
      tick();
    end
    chk("end_busy", CLR_BUSY, 0);
    chk("end_done", CLR_DONE, 1);
    chk("end_reject", WR_REJECT, 0);
    tick();
    chk("post_done", CLR_DONE, 0);
    for (int i = 0; i < 8; i++) begin
      rd1(3'(i), 16'h0000);
      rd2(3'(7 - i), 16'h0000);
      tick();
    end

    // reset in the middle of a sweep
    fill();
    CLR_REQ = 1'b1; tick();
    tick(); tick(); tick();
    chk("mid_busy_before_rst", CLR_BUSY, 1);
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    chk("mid_rst_busy", CLR_BUSY, 0);
    chk("mid_rst_done", CLR_DONE, 0);
    done_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (CLR_DONE) done_seen = 1'b1;
      tick();
    end
    chk("mid_rst_no_done", done_seen, 0);
    for (int i = 0; i < 8; i++) begin
      rd1(3'(i), 16'h0000);
      rd2(3'(i), 16'h0000);
      tick();
    end
    CLR_REQ = 1'b1; tick();
    busy_cnt = 0;
    for (int k = 0; k < 20 && !CLR_DONE; k++) begin
      if (CLR_BUSY) busy_cnt++;
      tick();
    end
    chk("restart_done", CLR_DONE, 1);
    chk("restart_busy_cycles", busy_cnt, 8);

    tick();
    @(negedge clk);
    #1;
    chk("q1_drained", exp1_q.size(), 0);
    chk("q2_drained", exp2_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
Parametrised successor to the LC-3b 8x16 register file. It has one write port and two independently enabled registered read ports. A multi-cycle hardware clear sequencer zeroes the array one entry per cycle, so a context reset needs no software loop. It sits in the datapath between the bus/ALU result mux and the SR1/SR2 operand registers.

Parameters:
WIDTH, 16, data width of each register in bits.
DEPTH, 8, number of registers; any value from 2 to 2^AW.
AW, 3, address width; 2^AW >= DEPTH is required.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous active-low reset.
WR_EN  input  1  write request this cycle.
WR_ADDR  input  AW  destination register.
WR_DATA  input  WIDTH  write data.
WR_REJECT  output  1  one-cycle pulse: a write was dropped because a clear sweep was in progress.
RD1_EN  input  1  sample read port 1.
RD1_ADDR  input  AW  source register, port 1.
RD1_DATA  output  WIDTH  registered read data, port 1.
RD2_EN  input  1  sample read port 2.
RD2_ADDR  input  AW  source register, port 2.
RD2_DATA  output  WIDTH  registered read data, port 2.
CLR_REQ  input  1  start a clear sweep (level; only sampled in IDLE).
CLR_BUSY  output  1  high while a sweep is running.
CLR_DONE  output  1  one-cycle pulse after the last entry is cleared.

Behaviour:
- All state changes on posedge clk.
- Reset (rst_n=0 at an edge):
  - all array entries = 0; RD1_DATA = RD2_DATA = 0.
  - WR_REJECT = CLR_BUSY = CLR_DONE = 0; FSM = IDLE; sweep counter = 0.
  - Reset overrides every other input, including mid-sweep.
- Reads:
  - latency is 1 cycle: RDn_DATA <= R[RDn_ADDR] when RDn_EN=1.
  - when RDn_EN=0, RDn_DATA holds its value.
  - RDn_ADDR >= DEPTH returns 0.
  - the two ports are fully independent; same address on both ports is legal.
- Writes:
  - in IDLE, WR_EN=1 and WR_ADDR < DEPTH: R[WR_ADDR] <= WR_DATA at the edge.
  - WR_ADDR >= DEPTH: write silently ignored, no WR_REJECT.
- Read/write same address, same cycle: the read returns the old contents, unless BYPASS_EN is defined (see below).
- FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP when CLR_REQ=1; counter <= 0.
  - A write presented in the same cycle as CLR_REQ is accepted; the sweep will later clear it.
  - In SWEEP: R[counter] <= 0 each cycle; counter increments; CLR_BUSY = 1.
    - Sweep takes exactly DEPTH cycles.
    - On the cycle that clears entry DEPTH-1: next state IDLE, CLR_DONE = 1 for the following cycle, CLR_BUSY = 0 from that cycle.
  - In SWEEP, CLR_REQ is ignored; no re-arm. CLR_REQ still high in the cycle CLR_DONE is asserted starts a new sweep.
  - In SWEEP, WR_EN=1 with WR_ADDR < DEPTH: write dropped; WR_REJECT = 1 in the next cycle.
  - In SWEEP, reads are allowed and return the array contents at sample time (entries may be partially cleared).
- CLR_BUSY, CLR_DONE and WR_REJECT are registered outputs.

Optional Feature:
Macro name: REG_FILE_BYPASS_EN.
- Defined: if a write is accepted in a cycle and RDn_EN=1 with RDn_ADDR == WR_ADDR, RDn_DATA <= WR_DATA (write-through forwarding), applied per port. No forwarding from a dropped (rejected) write.
- Not defined: the read returns the pre-write value (read-before-write), matching the legacy register file.

Test Plan:
- Reset then read all addresses: rst_n=0 for 1 cycle; read R0..R7 on both ports -> every RDn_DATA = 16'h0000, CLR_BUSY = 0.
- Write then read: write R3 = 16'hBEEF, then RD1_ADDR=3, RD2_ADDR=3 one cycle later -> both ports show 16'hBEEF one cycle after sampling; RD1_EN=0 keeps 16'hBEEF while R3 is overwritten with 16'h1234.
- Same-cycle collision: R5 = 16'hAAAA; write R5 = 16'h5555 while reading R5 in the same cycle:
  - without the macro -> 16'hAAAA.
  - with REG_FILE_BYPASS_EN -> 16'h5555.
- Clear sweep: fill R0..R7 with 16'h0101*i; pulse CLR_REQ:
  - CLR_BUSY high for exactly 8 cycles, then CLR_DONE pulses once.
  - all reads then return 0.
  - reading R7 at sweep cycle 2 returns 16'h0707.
- Write during sweep: WR_EN to R1 = 16'hFFFF at sweep cycle 4 -> WR_REJECT pulses once; R1 reads 0 after CLR_DONE.
- Reset mid-sweep: rst_n=0 at sweep cycle 3 -> next cycle CLR_BUSY = 0, CLR_DONE never pulses, all entries read 0; a new CLR_REQ restarts a full 8-cycle sweep.
